// File: rtl/ted_bus_dma_if.sv
// ted_bus_dma_if: bus and handshake signals between the video-fetch DMA
// engine, the video timing logic and the CPU shell.
//   enable            phi cycle boundary strobe (one clk wide)
//   dma_req/base/len  burst request from the video timing logic
//   cpu_rw            CPU read/write line (1 = read/idle, 0 = write)
//   data_in           shared read data bus
//   rdy, aec          CPU halt and bus-release controls
//   dma_addr          DMA address, 16'hffff when not mastering
//   dma_data          last fetched byte, qualified by dma_strobe
//   dma_done, busy    burst completion pulse and activity flag
// modport master: the DMA engine.  modport slave: its environment.
interface ted_bus_dma_if #(
    parameter int LEN_W = 6
);
    logic             enable;
    logic             dma_req;
    logic [15:0]      dma_base;
    logic [LEN_W-1:0] dma_len;
    logic             cpu_rw;
    logic [7:0]       data_in;
    logic             rdy;
    logic             aec;
    logic [15:0]      dma_addr;
    logic [7:0]       dma_data;
    logic             dma_strobe;
    logic             dma_done;
    logic             busy;

    modport master (
        input  enable, dma_req, dma_base, dma_len, cpu_rw, data_in,
        output rdy, aec, dma_addr, dma_data, dma_strobe, dma_done, busy
    );

    modport slave (
        output enable, dma_req, dma_base, dma_len, cpu_rw, data_in,
        input  rdy, aec, dma_addr, dma_data, dma_strobe, dma_done, busy
    );
endinterface

// File: rtl/ted_bus_dma.sv
// ted_bus_dma: bus-master side of the CPU halt / bus-release handshake.
// Halts the CPU with an early RDY warning (HALT_CYCLES enabled bus cycles,
// extended while the CPU is still writing), releases it via AEC, performs
// dma_len sequential reads from dma_base, then returns the bus.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    ted_bus_dma_if.master (request, CPU handshake and bus signals)
// All outputs are registered; state advances only on bus.enable.
module ted_bus_dma #(
    parameter int HALT_CYCLES = 3,
    parameter int LEN_W       = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    ted_bus_dma_if.master        bus
);
    localparam int CNT_W = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HALT,
        FETCH
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      base_q, base_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;
    logic             aec_q, aec_d;
    logic [15:0]      addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic [LEN_W-1:0] idx_next;

    assign idx_next = idx_q + LEN_W'(1);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        rdy_d    = rdy_q;
        aec_d    = aec_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                // A zero-length request never halts the CPU.
                if (bus.enable && bus.dma_req && (bus.dma_len != '0)) begin
                    base_d  = bus.dma_base;
                    len_d   = bus.dma_len;
                    idx_d   = '0;
                    cnt_d   = CNT_W'(HALT_CYCLES - 1);
                    state_d = HALT;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                end
            end
            HALT: begin
                if (bus.enable) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (bus.cpu_rw) begin
                        // CPU is reading (and therefore stopped by RDY): take the bus.
                        state_d = FETCH;
                        aec_d   = 1'b0;
                        addr_d  = base_q;
                    end
                    // Otherwise a CPU write is still in flight; wait it out.
                end
            end
            FETCH: begin
                if (bus.enable) begin
                    data_d   = bus.data_in;
                    strobe_d = 1'b1;
                    idx_d    = idx_next;
                    if (idx_next == len_q) begin
                        state_d = IDLE;
                        rdy_d   = 1'b1;
                        aec_d   = 1'b1;
                        addr_d  = 16'hffff;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // 16-bit add gives the ffff -> 0000 wrap for free.
                        addr_d = base_q + 16'(idx_next);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            base_q   <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b1;
            aec_q    <= 1'b1;
            addr_q   <= 16'hffff;
            data_q   <= 8'h00;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            aec_q    <= aec_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.rdy        = rdy_q;
    assign bus.aec        = aec_q;
    assign bus.dma_addr   = addr_q;
    assign bus.dma_data   = data_q;
    assign bus.dma_strobe = strobe_q;
    assign bus.dma_done   = done_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_ted_bus_dma.sv
// tb_ted_bus_dma: directed bench for ted_bus_dma with a strobe scoreboard.
// Memory model: byte at address A is A[7:0] + A[15:8] + 8'h11.
module tb_ted_bus_dma;
    logic clk;
    logic reset;

    ted_bus_dma_if #(.LEN_W(6)) bus ();

    ted_bus_dma #(.HALT_CYCLES(3), .LEN_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple ROM on the shared bus.
    always_comb bus.data_in = bus.dma_addr[7:0] + bus.dma_addr[15:8] + 8'h11;

    typedef struct packed {
        logic [7:0] data;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   vecs = 0;
    int   miss = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enp();
        bus.enable = 1'b1;
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic request(input logic [15:0] base, input logic [5:0] len);
        bus.dma_req  = 1'b1;
        bus.dma_base = base;
        bus.dma_len  = len;
        enp();
        bus.dma_req  = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic done);
        exp_t e;
        e.data = d;
        e.done = done;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe consumes one expected entry.
    always @(posedge clk) begin
        #1;
        if (bus.dma_strobe) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 16'(bus.dma_data), 16'hxxxx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_data", 16'(bus.dma_data), 16'(e.data));
                chk("strobe_done", 16'(bus.dma_done), 16'(e.done));
            end
        end else if (bus.dma_done) begin
            chk("done_without_strobe", 16'(bus.dma_done), 16'h0);
        end
    end

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.dma_req  = 1'b0;
        bus.dma_base = 16'h0;
        bus.dma_len  = 6'd0;
        bus.cpu_rw   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rdy",    16'(bus.rdy),        16'h1);
        chk("rst_aec",    16'(bus.aec),        16'h1);
        chk("rst_addr",   bus.dma_addr,        16'hffff);
        chk("rst_data",   16'(bus.dma_data),   16'h00);
        chk("rst_strobe", 16'(bus.dma_strobe), 16'h0);
        chk("rst_done",   16'(bus.dma_done),   16'h0);
        chk("rst_busy",   16'(bus.busy),       16'h0);

        // Basic burst 0C00 x4: data 1D 1E 1F 20.
        push(8'h1D, 1'b0); push(8'h1E, 1'b0); push(8'h1F, 1'b0); push(8'h20, 1'b1);
        request(16'h0C00, 6'd4);
        chk("b_rdy_low",  16'(bus.rdy),  16'h0);
        chk("b_busy",     16'(bus.busy), 16'h1);
        chk("b_aec_e0",   16'(bus.aec),  16'h1);
        chk("b_addr_e0",  bus.dma_addr,  16'hffff);
        enp(); chk("b_aec_h1", 16'(bus.aec), 16'h1);
        enp(); chk("b_aec_h2", 16'(bus.aec), 16'h1);
        enp(); chk("b_aec_h3", 16'(bus.aec), 16'h0);
        chk("b_addr0", bus.dma_addr, 16'h0C00);
        enp(); chk("b_addr1", bus.dma_addr, 16'h0C01);
        enp(); chk("b_addr2", bus.dma_addr, 16'h0C02);
        enp(); chk("b_addr3", bus.dma_addr, 16'h0C03);
        enp();
        chk("b_end_rdy",  16'(bus.rdy),      16'h1);
        chk("b_end_aec",  16'(bus.aec),      16'h1);
        chk("b_end_addr", bus.dma_addr,      16'hffff);
        chk("b_end_busy", 16'(bus.busy),     16'h0);
        chk("b_end_done", 16'(bus.dma_done), 16'h1);
        tick();
        chk("b_done_pulse", 16'(bus.dma_done), 16'h0);

        // Write extension: CPU writing on the 3rd HALT enable. Data 21 22.
        push(8'h21, 1'b0); push(8'h22, 1'b1);
        request(16'h1000, 6'd2);
        enp(); enp();
        bus.cpu_rw = 1'b0;
        enp(); chk("w_aec_ext", 16'(bus.aec), 16'h1);
        chk("w_addr_ext", bus.dma_addr, 16'hffff);
        bus.cpu_rw = 1'b1;
        enp(); chk("w_aec_fetch", 16'(bus.aec), 16'h0);
        chk("w_addr0", bus.dma_addr, 16'h1000);
        enp(); chk("w_addr1", bus.dma_addr, 16'h1001);
        enp(); chk("w_end_rdy", 16'(bus.rdy), 16'h1);

        // Address wrap FFFE x3: data 0E 0F 11.
        push(8'h0E, 1'b0); push(8'h0F, 1'b0); push(8'h11, 1'b1);
        request(16'hFFFE, 6'd3);
        enp(); enp(); enp();
        chk("wr_addr0", bus.dma_addr, 16'hFFFE);
        enp(); chk("wr_addr1", bus.dma_addr, 16'hFFFF);
        enp(); chk("wr_addr2", bus.dma_addr, 16'h0000);
        enp(); chk("wr_end_done", 16'(bus.dma_done), 16'h1);
        chk("wr_end_addr", bus.dma_addr, 16'hffff);

        // Zero-length request is ignored.
        request(16'h1234, 6'd0);
        chk("z_rdy",  16'(bus.rdy),  16'h1);
        chk("z_busy", 16'(bus.busy), 16'h0);

        // Request while busy is ignored. Burst 2000 x3: data 31 32 33.
        push(8'h31, 1'b0); push(8'h32, 1'b0); push(8'h33, 1'b1);
        request(16'h2000, 6'd3);
        bus.dma_req  = 1'b1;
        bus.dma_base = 16'h5000;
        bus.dma_len  = 6'd1;
        enp(); enp(); enp();
        chk("q_addr0", bus.dma_addr, 16'h2000);
        enp(); chk("q_addr1", bus.dma_addr, 16'h2001);
        enp(); chk("q_addr2", bus.dma_addr, 16'h2002);
        enp(); chk("q_end_busy", 16'(bus.busy), 16'h0);
        bus.dma_req = 1'b0;
        tick(); chk("q_no_restart", 16'(bus.rdy), 16'h1);

        // Reset at idx=2 of a 10-fetch burst. Data 41 42 before reset.
        push(8'h41, 1'b0); push(8'h42, 1'b0);
        request(16'h3000, 6'd10);
        enp(); enp(); enp();
        enp(); enp();
        chk("r_addr_idx2", bus.dma_addr, 16'h3002);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_rdy",    16'(bus.rdy),        16'h1);
        chk("r_aec",    16'(bus.aec),        16'h1);
        chk("r_addr",   bus.dma_addr,        16'hffff);
        chk("r_busy",   16'(bus.busy),       16'h0);
        chk("r_done",   16'(bus.dma_done),   16'h0);
        chk("r_strobe", 16'(bus.dma_strobe), 16'h0);
        // Fresh burst 4000 x2: data 51 52.
        push(8'h51, 1'b0); push(8'h52, 1'b1);
        request(16'h4000, 6'd2);
        enp(); enp(); enp();
        chk("r2_addr0", bus.dma_addr, 16'h4000);
        enp(); chk("r2_addr1", bus.dma_addr, 16'h4001);
        enp(); chk("r2_done", 16'(bus.dma_done), 16'h1);

        // Enable gap mid-FETCH. Burst 0100 x3: data 12 13 14.
        push(8'h12, 1'b0); push(8'h13, 1'b0); push(8'h14, 1'b1);
        request(16'h0100, 6'd3);
        enp(); enp(); enp();
        enp(); chk("g_addr1", bus.dma_addr, 16'h0101);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("g_addr_hold", bus.dma_addr, 16'h0101);
            chk("g_no_strobe", 16'(bus.dma_strobe), 16'h0);
        end
        enp(); chk("g_addr2", bus.dma_addr, 16'h0102);
        enp(); chk("g_done", 16'(bus.dma_done), 16'h1);

        tick();
        tick();
        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule

// File: doc/ted_bus_dma.md
Name: ted_bus_dma

Overview:
- Bus-master side of the CPU halt/bus-release handshake: drives the CPU core's `rdy` and `aec` inputs.
- Steals a burst of memory read cycles for the video fetch logic (character/attribute line fetch).
- Sits between the video timing logic and the shared address/data bus, alongside the CPU shell.
- Halts the CPU with an early RDY warning so pending CPU write cycles complete, takes the bus, performs N sequential reads, then returns the bus.

Parameters:
- HALT_CYCLES, 3, number of enabled bus cycles RDY is held low before AEC drops (covers up to 3 back-to-back CPU writes).
- LEN_W, 6, width of burst length input (max 63 fetches).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  one-clk strobe marking a bus (phi) cycle boundary; all state advances only when enable=1.
- dma_req  in  1  burst request, sampled only in IDLE on enable.
- dma_base  in  16  start address of burst, latched with request.
- dma_len  in  LEN_W  number of reads, latched with request.
- cpu_rw  in  1  CPU bus rw (1=read/idle, 0=write), from the CPU shell.
- data_in  in  8  shared read data bus.
- rdy  out  1  to CPU; 0 = halt on next read.
- aec  out  1  to CPU; 0 = CPU address/data released (CPU shell forces address 16'hffff, rw=1).
- dma_addr  out  16  bus address when mastering, 16'hffff otherwise (emulated tristate, AND-combined with CPU address).
- dma_data  out  8  last fetched byte.
- dma_strobe  out  1  one-clk pulse, dma_data valid.
- dma_done  out  1  one-clk pulse after last fetch.
- busy  out  1  high from accepted request until return to IDLE.

Behaviour:
- Reset values: rdy=1, aec=1, dma_addr=16'hffff, dma_data=8'h00, dma_strobe=0, dma_done=0, busy=0, state=IDLE. All outputs are registered.
- Reset mid-burst: the next clk forces the reset values. No done pulse; the latched request is discarded.
- IDLE:
  - On enable & dma_req & dma_len!=0: latch base/len, idx=0, cnt=HALT_CYCLES-1, go HALT, busy=1, rdy=0.
  - dma_len=0: request ignored, no halt, no done.
- HALT (rdy=0, aec=1, dma_addr=ffff):
  - On enable: if cnt!=0, cnt<=cnt-1.
  - Else if cpu_rw=1, go FETCH: aec<=0, dma_addr<=base.
  - Else (CPU still writing on final counted cycle), stay in HALT; extension is unbounded until cpu_rw=1.
- FETCH (rdy=0, aec=0, dma_addr=base+idx, 16-bit wrap ffff->0000):
  - On each enable: dma_data<=data_in, dma_strobe<=1 for one clk, idx<=idx+1, dma_addr<=base+idx+1.
  - On the enable capturing fetch number len: go IDLE. Same clk: rdy<=1, aec<=1, dma_addr<=ffff, busy<=0, dma_done<=1 for one clk, coincident with the final strobe.
- Latency: request enable E0 -> rdy low after E0. First fetch address valid after enable E0+HALT_CYCLES (no extension). Bus returned after enable E0+HALT_CYCLES+len.
- dma_req while busy: ignored (no queueing).
- Between enables: no state change, strobes deassert after one clk.
- HALT_CYCLES=1 is legal (cnt starts at 0, FETCH decision on first HALT enable).

Test Plan:
- Basic burst: base=16'h0C00, len=4, cpu_rw=1. Expect:
  - rdy low 1 clk after request enable, aec low after 3rd HALT enable.
  - Addresses 0C00..0C03, 4 dma_strobe pulses with data_in values.
  - dma_done on the 4th, then rdy=aec=1, dma_addr=ffff.
- Write extension: cpu_rw=0 on the 3rd HALT enable and one more enable -> aec stays 1 one extra enable; first FETCH on the enable where cpu_rw=1.
- Wrap: base=16'hFFFE, len=3 -> addresses FFFE, FFFF, 0000; done after the 3rd.
- dma_len=0 and dma_req while busy -> no rdy change / no restart; running burst count unaffected.
- Reset asserted during FETCH idx=2 of len=10 -> next clk rdy=1, aec=1, dma_addr=ffff, busy=0, no dma_done. A new request afterwards starts cleanly from the new base.
- enable low for 5 clks mid-FETCH -> dma_addr and idx hold, no strobes; resumes on the next enable.
